// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Program-counter / next-PC stage sitting directly in front of the control
// decoder. Each cycle ProgCtr addresses the instruction ROM. The decoder's
// Jump/Branch/BranchCond/PCTarg and the ALU flags select the next PC. A
// 16-entry programmable branch-target LUT supplies the redirect targets. A
// Start/Halt/Done handshake controls the run.
//
// Ports
//   Clk        : single clock; all state updates on the rising edge
//   Reset      : synchronous, active-low; overrides every other input
//   Start      : level; begin execution at StartAddr (IDLE or HALT only)
//   StartAddr  : PC loaded on an accepted Start
//   Halt       : decoded halt at the current PC
//   Stall      : hold the PC this cycle (multi-cycle memory op)
//   Jump       : unconditional redirect to LUT[PCTarg]
//   Branch     : conditional redirect to LUT[PCTarg]
//   BranchCond : 00 Z, 01 !Z, 10 N, 11 !N  (registered flags)
//   PCTarg     : LUT read index
//   FlagWe     : capture ZeroIn/NegIn into the flag registers
//   ZeroIn     : ALU zero result
//   NegIn      : ALU negative result
//   LutWe      : LUT write enable
//   LutAddr    : LUT write index
//   LutData    : LUT write data
//   ProgCtr    : registered instruction ROM address
//   Running    : high while in RUN
//   Done       : high while in HALT
//   Taken      : combinational; the next PC is a redirect this cycle
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int PC_W  = 10,
    parameter int LUT_N = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Halt,
    input  logic            Stall,
    input  logic            Jump,
    input  logic            Branch,
    input  logic [1:0]      BranchCond,
    input  logic [3:0]      PCTarg,
    input  logic            FlagWe,
    input  logic            ZeroIn,
    input  logic            NegIn,
    input  logic            LutWe,
    input  logic [3:0]      LutAddr,
    input  logic [PC_W-1:0] LutData,
    output logic [PC_W-1:0] ProgCtr,
    output logic            Running,
    output logic            Done,
    output logic            Taken
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            z_reg, n_reg;
    logic [PC_W-1:0] lut_reg [LUT_N];
    logic [LUT_N-1:0] lut_sel;
    logic [PC_W-1:0] target;
    logic            cond_true;

    // -------------------------------------------------------------------------
    // Branch-target LUT. Per-entry write selects are decoded here; the read
    // is combinational so a same-cycle write to the index being read still
    // returns the old entry (the new value lands at the edge).
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < LUT_N; gi++) begin : g_lut_sel
            assign lut_sel[gi] = LutWe && (LutAddr == 4'(gi));
        end
    endgenerate

    always_ff @(posedge Clk) begin
        for (int i = 0; i < LUT_N; i++) begin
            if (!Reset) begin
                lut_reg[i] <= '0;
            end else if (lut_sel[i]) begin
                lut_reg[i] <= LutData;
            end
        end
    end

    assign target = lut_reg[PCTarg];

    // -------------------------------------------------------------------------
    // Flag registers. Captured in any state, including during Stall. Branch
    // conditions read the registered copies only, so a compare issued in the
    // same cycle as a branch does not affect that branch.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            z_reg <= 1'b0;
            n_reg <= 1'b0;
        end else if (FlagWe) begin
            z_reg <= ZeroIn;
            n_reg <= NegIn;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (BranchCond)
            2'b00:   cond_true = z_reg;
            2'b01:   cond_true = ~z_reg;
            2'b10:   cond_true = n_reg;
            default: cond_true = ~n_reg;
        endcase
    end

    // Outputs decoded from registered state only.
    assign Running = (state_reg == RUN);
    assign Done    = (state_reg == HALT);
    assign ProgCtr = pc_reg;

    // Jump and Branch share the same target, so Jump winning needs no mux.
    assign Taken = Running & ~Stall & ~Halt & (Jump | (Branch & cond_true));

    // -------------------------------------------------------------------------
    // Run-control FSM and next-PC selection.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            IDLE, HALT: begin
                if (Start) begin
                    pc_next    = StartAddr;
                    state_next = RUN;
                end
            end
            RUN: begin
                // Stall outranks everything; Start is ignored while running.
                if (!Stall) begin
                    if (Halt) begin
                        state_next = HALT;
                    end else if (Taken) begin
                        pc_next = target;
                    end else begin
                        // Natural modulo 2**PC_W wrap: all-ones goes to 0.
                        pc_next = pc_reg + PC_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Table-driven directed vectors for the named scenarios (sequential run,
// LUT jump, branch/flag timing for every condition, stall/halt priority, PC
// wrap, same-cycle LUT hazard, mid-run reset), followed by a randomized phase
// compared against a behavioural model of the fetch rules.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int PC_W  = 10;
    localparam int LUT_N = 16;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic [PC_W-1:0] StartAddr;
    logic            Halt;
    logic            Stall;
    logic            Jump;
    logic            Branch;
    logic [1:0]      BranchCond;
    logic [3:0]      PCTarg;
    logic            FlagWe;
    logic            ZeroIn;
    logic            NegIn;
    logic            LutWe;
    logic [3:0]      LutAddr;
    logic [PC_W-1:0] LutData;
    logic [PC_W-1:0] ProgCtr;
    logic            Running;
    logic            Done;
    logic            Taken;

    fetch_unit #(.PC_W(PC_W), .LUT_N(LUT_N)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
        .Halt(Halt), .Stall(Stall), .Jump(Jump), .Branch(Branch),
        .BranchCond(BranchCond), .PCTarg(PCTarg), .FlagWe(FlagWe),
        .ZeroIn(ZeroIn), .NegIn(NegIn), .LutWe(LutWe), .LutAddr(LutAddr),
        .LutData(LutData), .ProgCtr(ProgCtr), .Running(Running),
        .Done(Done), .Taken(Taken)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic            rst;
        logic            start;
        logic [PC_W-1:0] saddr;
        logic            halt;
        logic            stall;
        logic            jump;
        logic            branch;
        logic [1:0]      bc;
        logic [3:0]      targ;
        logic            fwe;
        logic            zi;
        logic            ni;
        logic            lwe;
        logic [3:0]      la;
        logic [PC_W-1:0] ld;
        logic            e_taken;
        logic [PC_W-1:0] e_pc;
        logic            e_run;
        logic            e_done;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = halted.
    int m_st;
    int m_pc;
    bit m_z;
    bit m_n;
    int m_lut [LUT_N];

    function automatic vec_t mk(int rst, int start, int saddr, int halt,
                                int stall, int jump, int branch, int bc,
                                int targ, int fwe, int zi, int ni, int lwe,
                                int la, int ld, int et, int epc, int er,
                                int ed);
        vec_t v;
        v.rst     = (rst != 0);
        v.start   = (start != 0);
        v.saddr   = PC_W'(saddr);
        v.halt    = (halt != 0);
        v.stall   = (stall != 0);
        v.jump    = (jump != 0);
        v.branch  = (branch != 0);
        v.bc      = 2'(bc);
        v.targ    = 4'(targ);
        v.fwe     = (fwe != 0);
        v.zi      = (zi != 0);
        v.ni      = (ni != 0);
        v.lwe     = (lwe != 0);
        v.la      = 4'(la);
        v.ld      = PC_W'(ld);
        v.e_taken = (et != 0);
        v.e_pc    = PC_W'(epc);
        v.e_run   = (er != 0);
        v.e_done  = (ed != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp, input int idx);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    function automatic bit m_cond(logic [1:0] bc);
        case (bc)
            2'b00:   return m_z;
            2'b01:   return !m_z;
            2'b10:   return m_n;
            default: return !m_n;
        endcase
    endfunction

    // Advance the model by one clock edge according to the fetch rules.
    task automatic m_commit(input vec_t v);
        int  nxt_pc;
        int  nxt_st;
        bit  redirect;
        if (!v.rst) begin
            m_st = 0;
            m_pc = 0;
            m_z  = 0;
            m_n  = 0;
            for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
        end else begin
            nxt_pc   = m_pc;
            nxt_st   = m_st;
            redirect = v.jump || (v.branch && m_cond(v.bc));
            if (m_st == 1) begin
                if (v.stall) begin
                    nxt_pc = m_pc;
                end else if (v.halt) begin
                    nxt_st = 2;
                end else if (redirect) begin
                    nxt_pc = m_lut[v.targ];
                end else begin
                    nxt_pc = (m_pc + 1) % (1 << PC_W);
                end
            end else if (v.start) begin
                nxt_pc = int'(v.saddr);
                nxt_st = 1;
            end
            if (v.fwe) begin
                m_z = v.zi;
                m_n = v.ni;
            end
            if (v.lwe) m_lut[v.la] = int'(v.ld);
            m_pc = nxt_pc;
            m_st = nxt_st;
        end
    endtask

    // Drive one cycle of inputs, check Taken before the edge and the
    // registered outputs just after it.
    task automatic apply(input vec_t vin, input bit use_model, input int idx);
        vec_t v;
        bit   m_taken;
        v = vin;
        Reset      = v.rst;
        Start      = v.start;
        StartAddr  = v.saddr;
        Halt       = v.halt;
        Stall      = v.stall;
        Jump       = v.jump;
        Branch     = v.branch;
        BranchCond = v.bc;
        PCTarg     = v.targ;
        FlagWe     = v.fwe;
        ZeroIn     = v.zi;
        NegIn      = v.ni;
        LutWe      = v.lwe;
        LutAddr    = v.la;
        LutData    = v.ld;
        m_taken = (m_st == 1) && !v.stall && !v.halt &&
                  (v.jump || (v.branch && m_cond(v.bc)));
        m_commit(v);
        if (use_model) begin
            v.e_taken = m_taken;
            v.e_pc    = PC_W'(m_pc);
            v.e_run   = (m_st == 1);
            v.e_done  = (m_st == 2);
        end
        #3;
        chk("taken", 32'(Taken), 32'(v.e_taken), idx);
        @(posedge Clk);
        #1;
        chk("prog_ctr", 32'(ProgCtr), 32'(v.e_pc), idx);
        chk("running", 32'(Running), 32'(v.e_run), idx);
        chk("done", 32'(Done), 32'(v.e_done), idx);
        $display("step %0d: rst=%0b start=%0b halt=%0b stall=%0b jump=%0b branch=%0b bc=%0d targ=%0d -> pc=%0d run=%0b done=%0b taken=%0b",
                 idx, v.rst, v.start, v.halt, v.stall, v.jump, v.branch, v.bc,
                 v.targ, ProgCtr, Running, Done, v.e_taken);
    endtask

    vec_t vecs[$];

    initial begin
        // Columns: rst start saddr | halt stall jump branch bc targ |
        //          fwe zi ni | lwe la ld | exp: taken pc run done
        vecs.push_back(mk(0,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,0,0,0));
        vecs.push_back(mk(0,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,0,0,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,0,0,0));
        vecs.push_back(mk(1,1,5,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,5,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,6,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 1,3,200,  0,7,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,8,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,3, 0,0,0, 0,0,0,    1,200,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 1,4,10,   0,201,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,4, 0,0,0, 0,0,0,    1,10,1,0));
        // Z=1 captured at pc 10, branch on Z at pc 11.
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 1,1,0, 0,0,0,    0,11,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,0,3, 0,0,0, 0,0,0,    1,200,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 1,0,0, 0,0,0,    0,201,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,4, 0,0,0, 0,0,0,    1,10,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,11,1,0));
        // Branch in the same cycle as FlagWe sees old Z=0.
        vecs.push_back(mk(1,0,0,    0,0,0,1,0,3, 1,1,0, 0,0,0,    0,12,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,1,3, 0,0,0, 0,0,0,    0,13,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 1,0,0, 0,0,0,    0,14,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,1,3, 0,0,0, 0,0,0,    1,200,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,2,4, 0,0,0, 0,0,0,    0,201,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 1,0,1, 0,0,0,    0,202,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,2,4, 0,0,0, 0,0,0,    1,10,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,3,3, 0,0,0, 0,0,0,    0,11,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 1,0,0, 0,0,0,    0,12,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,3,3, 0,0,0, 0,0,0,    1,200,1,0));
        // Stall beats Jump for three cycles, then Halt beats Jump.
        vecs.push_back(mk(1,0,0,    0,1,1,0,0,4, 0,0,0, 0,0,0,    0,200,1,0));
        vecs.push_back(mk(1,0,0,    0,1,1,0,0,4, 0,0,0, 0,0,0,    0,200,1,0));
        vecs.push_back(mk(1,0,0,    0,1,1,0,0,4, 0,0,0, 0,0,0,    0,200,1,0));
        vecs.push_back(mk(1,0,0,    1,0,1,0,0,4, 0,0,0, 0,0,0,    0,200,0,1));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,200,0,1));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,4, 0,0,0, 0,0,0,    0,200,0,1));
        vecs.push_back(mk(1,1,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,0,1,0));
        // Start while running is ignored.
        vecs.push_back(mk(1,1,77,   0,0,0,0,0,0, 0,0,0, 0,0,0,    0,1,1,0));
        vecs.push_back(mk(1,0,0,    1,0,0,0,0,0, 0,0,0, 0,0,0,    0,1,0,1));
        // Wrap from all-ones.
        vecs.push_back(mk(1,1,1023, 0,0,0,0,0,0, 0,0,0, 0,0,0,    0,1023,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,0,1,0));
        // Same-cycle LUT write/read of index 7.
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 1,7,50,   0,1,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,7, 0,0,0, 1,7,60,   1,50,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,7, 0,0,0, 0,0,0,    1,60,1,0));
        // Mid-run reset with Jump/Start/LutWe active.
        vecs.push_back(mk(0,1,5,    0,0,1,0,0,3, 0,0,0, 0,0,0,    1,0,0,0));
        vecs.push_back(mk(0,1,5,    0,0,0,0,0,0, 0,0,0, 1,3,99,   0,0,0,0));
        // LUT write while idle.
        vecs.push_back(mk(1,0,0,    0,0,0,0,0,0, 0,0,0, 1,9,333,  0,0,0,0));
        vecs.push_back(mk(1,1,9,    0,0,0,0,0,0, 0,0,0, 0,0,0,    0,9,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,3, 0,0,0, 0,0,0,    1,0,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,0,4, 0,0,0, 0,0,0,    0,1,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,1,4, 0,0,0, 0,0,0,    1,0,1,0));
        vecs.push_back(mk(1,0,0,    0,0,0,1,2,4, 0,0,0, 0,0,0,    0,1,1,0));
        vecs.push_back(mk(1,0,0,    0,0,1,0,0,9, 0,0,0, 0,0,0,    1,333,1,0));

        // Bring the DUT to a known state before the first checked vector.
        m_st = 0; m_pc = 0; m_z = 0; m_n = 0;
        for (int i = 0; i < LUT_N; i++) m_lut[i] = 0;
        Reset = 1'b0; Start = 1'b0; StartAddr = '0; Halt = 1'b0;
        Stall = 1'b0; Jump = 1'b0; Branch = 1'b0; BranchCond = 2'b00;
        PCTarg = 4'd0; FlagWe = 1'b0; ZeroIn = 1'b0; NegIn = 1'b0;
        LutWe = 1'b0; LutAddr = 4'd0; LutData = '0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 1'b0, i);
        end

        // Randomized phase against the model.
        for (int i = 0; i < 1500; i++) begin
            vec_t r;
            int   sa;
            sa = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
            r = mk(($urandom_range(0, 63) == 0) ? 0 : 1,
                   ($urandom_range(0, 7) == 0) ? 1 : 0,
                   sa,
                   ($urandom_range(0, 15) == 0) ? 1 : 0,
                   ($urandom_range(0, 5) == 0) ? 1 : 0,
                   ($urandom_range(0, 7) == 0) ? 1 : 0,
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? 1 : 0,
                   int'($urandom_range(0, 1)),
                   int'($urandom_range(0, 1)),
                   ($urandom_range(0, 7) == 0) ? 1 : 0,
                   int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 1023)),
                   0, 0, 0, 0);
            apply(r, 1'b1, 1000 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
